// File: rtl/rgb_g_seq.sv
// Sequential RGB-to-grayscale converter: one shared shift-add MAC, one channel per cycle.
// Define RGB_G_SEQ_ROUND_EN for round-half-up (saturating) output instead of truncation.
module rgb_g_seq #(
  parameter int n = 8,
  parameter int m = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] r,
  input  logic [n-1:0] g,
  input  logic [n-1:0] b,
  input  logic         ntsc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [m-1:0] y,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, ACC_R, ACC_G, ACC_B, OUT} state_t;

  state_t       r_state;
  logic [n-1:0] r_r, r_g, r_b;
  logic         r_ntsc;
  logic [n+6:0] r_acc;
  logic [m-1:0] r_y;
  logic         r_out_valid;

  logic [n-1:0] w_chan;
  logic [n+6:0] w_prod;
  logic [n+6:0] w_acc_next;
  logic [m-1:0] w_y_next;

  function automatic logic [n+6:0] sh(input logic [n-1:0] x, input int k);
    logic [n+6:0] xe;
    xe = {{7{1'b0}}, x};
    return xe << k;
  endfunction

  // Channel mux, constant-coefficient product and the single accumulate adder
  always_comb begin
    w_chan = r_r;
    w_prod = '0;
    case (r_state)
      ACC_G:   w_chan = r_g;
      ACC_B:   w_chan = r_b;
      default: w_chan = r_r;
    endcase
    if (!r_ntsc) begin
      case (r_state)
        ACC_R:   w_prod = sh(w_chan, 4) + sh(w_chan, 3) + sh(w_chan, 1) + sh(w_chan, 0); // 27
        ACC_G:   w_prod = sh(w_chan, 6) + sh(w_chan, 4) + sh(w_chan, 3) + sh(w_chan, 2); // 92
        ACC_B:   w_prod = sh(w_chan, 3) + sh(w_chan, 0);                                 // 9
        default: w_prod = '0;
      endcase
    end else begin
      case (r_state)
        ACC_R:   w_prod = sh(w_chan, 5) + sh(w_chan, 2) + sh(w_chan, 1);                 // 38
        ACC_G:   w_prod = sh(w_chan, 6) + sh(w_chan, 3) + sh(w_chan, 1) + sh(w_chan, 0); // 75
        ACC_B:   w_prod = sh(w_chan, 3) + sh(w_chan, 2) + sh(w_chan, 1) + sh(w_chan, 0); // 15
        default: w_prod = '0;
      endcase
    end
    w_acc_next = r_acc + w_prod;
  end

`ifdef RGB_G_SEQ_ROUND_EN
  generate
    if (m < n + 7) begin : g_round
      // Adding half an output LSB then truncating equals adding the bit just below the kept field
      logic [m:0] w_rsum;
      assign w_rsum   = {1'b0, w_acc_next[n+6 -: m]} + {{m{1'b0}}, w_acc_next[n+6-m]};
      assign w_y_next = w_rsum[m] ? {m{1'b1}} : w_rsum[m-1:0];
    end else begin : g_exact
      assign w_y_next = w_acc_next[n+6 -: m];
    end
  endgenerate
`else
  assign w_y_next = w_acc_next[n+6 -: m];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
      r_ntsc      <= 1'b0;
      r_acc       <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_r     <= r;
            r_g     <= g;
            r_b     <= b;
            r_ntsc  <= ntsc;
            r_acc   <= '0;
            r_state <= ACC_R;
          end
        end
        ACC_R: begin
          r_acc   <= w_acc_next;
          r_state <= ACC_G;
        end
        ACC_G: begin
          r_acc   <= w_acc_next;
          r_state <= ACC_B;
        end
        ACC_B: begin
          r_acc       <= w_acc_next;
          r_y         <= w_y_next;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign y         = r_y;

endmodule

// File: tb/tb_rgb_g_seq.sv
// Self-checking bench for rgb_g_seq (n=8, m=8): per-cycle reference model plus directed vectors.
module tb_rgb_g_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] r = '0, g = '0, b = '0;
  logic       ntsc = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] y;
  logic       busy;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;

`ifdef RGB_G_SEQ_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    int yv;
    int due;
  } exp_t;

  exp_t q[$];
  int   last_y = 0;
  bit   armed = 1'b0;

  rgb_g_seq #(.n(8), .m(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .r(r), .g(g), .b(b), .ntsc(ntsc), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Weighted sum over 128, optionally rounded half-up, clamped to 8 bits
  function automatic int model_y(input int rr, input int gg, input int bb, input bit nt);
    int s;
    s = nt ? (38 * rr + 75 * gg + 15 * bb) : (27 * rr + 92 * gg + 9 * bb);
    if (RND) s = s + 64;
    s = s / 128;
    if (s > 255) s = 255;
    return s;
  endfunction

  // Reference: a pixel accepted at cycle c is presented from cycle c+4 until taken
  always @(negedge clk) begin : model_cmp
    bit idle;
    bit ev;
    idle = (q.size() == 0);
    if (armed) begin
      ev = !idle && (cyc >= q[0].due);
      if (ev) last_y = q[0].yv;
      chk("m_out_valid", 32'(out_valid), 32'(ev));
      chk("m_in_ready", 32'(in_ready), 32'(idle));
      chk("m_busy", 32'(busy), 32'(!idle));
      chk("m_y", 32'(y), 32'(last_y));
      if (ev && out_ready) void'(q.pop_front());
    end
    if (!rst_n) begin
      q.delete();
      last_y = 0;
      armed  = 1'b1;
    end else if (armed && in_valid && idle) begin
      q.push_back('{model_y(int'(r), int'(g), int'(b), ntsc), cyc + 4});
    end
    cyc++;
  end

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pix(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                     input logic nt, input int ey, input string nm);
    bit ok;
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; r = rr; g = gg; b = bb; ntsc = nt;
    wait_accept(ok);
    chk({nm, "_accept"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); ntsc = 1'($urandom);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'd4);
    chk({nm, "_y"}, 32'(y), 32'(ey));
    $display("pixel %s: r=%0d g=%0d b=%0d ntsc=%0d y=%0d latency=%0d", nm, rr, gg, bb, nt, y, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    int   bad;
    bit   seen;
    logic [7:0] hold_y;

    // Reset held with a pixel offered
    in_valid = 1'b1; r = 8'd255; g = 8'd0; b = 8'd0; ntsc = 1'b0; rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    pix(8'd255, 8'd0,   8'd0,   1'b0, RND ? 54 : 53,   "cie_red");
    pix(8'd0,   8'd255, 8'd0,   1'b1, 149,             "ntsc_green");
    pix(8'd0,   8'd0,   8'd255, 1'b1, RND ? 30 : 29,   "ntsc_blue");
    pix(8'd255, 8'd255, 8'd255, 1'b0, 255,             "cie_white");
    pix(8'd255, 8'd255, 8'd255, 1'b1, 255,             "ntsc_white");
    pix(8'd100, 8'd150, 8'd200, 1'b0, RND ? 143 : 142, "cie_mix");
    pix(8'd100, 8'd150, 8'd200, 1'b1, 141,             "ntsc_mix");
    pix(8'd0,   8'd0,   8'd0,   1'b0, 0,               "black");

    // Back-pressure: sink stalls 10 cycles while a new pixel is offered
    @(posedge clk); #1;
    out_ready = 1'b0;
    pix(8'd10, 8'd20, 8'd30, 1'b0, RND ? 19 : 18, "bp");
    hold_y = y;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; r = 8'd200; g = 8'd100; b = 8'd50; ntsc = 1'b1;
      @(negedge clk);
      if (out_valid !== 1'b1 || y !== hold_y || in_ready !== 1'b0) bad++;
    end
    chk("bp_hold_violations", 32'(bad), 32'd0);
    $display("backpressure: held y=%0d for 10 cycles, violations=%0d", hold_y, bad);
    @(posedge clk); #1;
    out_ready = 1'b1;
    pix(8'd200, 8'd100, 8'd50, 1'b1, RND ? 124 : 123, "bp_next");

    // Abort: reset lands while the green channel is being accumulated
    @(posedge clk); #1;
    in_valid = 1'b1; r = 8'd255; g = 8'd0; b = 8'd0; ntsc = 1'b0;
    wait_accept(ok);
    chk("abort_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_out_valid", 32'(seen), 32'd0);
    $display("abort: out_valid seen after mid-pixel reset=%0d", seen);
    pix(8'd255, 8'd0, 8'd0, 1'b0, RND ? 54 : 53, "abort_next");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
